uart_mmio_periph: RTL and testbench

//  Memory-mapped UART peripheral directly downstream of the core's Memory stage data port.

---
 rtl/uart_mmio_periph.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_uart_mmio_periph.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_periph.sv
// Memory-mapped UART: TXDATA/RXDATA/STATUS/CTRL window, TX/RX FIFOs, 8N1 serial engines.
// Define UART_PARITY_EN to add an even-parity bit to both TX and RX frames.
module uart_mmio_periph #(
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned TX_DEPTH     = 8,
  parameter int unsigned RX_DEPTH     = 8
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_din,
  input  logic        mem_wea,
  input  logic        mem_rea,
  input  logic [3:0]  mem_en,
  output logic        mmio_hit,
  output logic [31:0] mmio_dout,
  output logic        mem_hold,
  output logic        uart_IRQ,
  input  logic        rx,
  output logic        tx
);

  localparam int unsigned TxAw = $clog2(TX_DEPTH);
  localparam int unsigned RxAw = $clog2(RX_DEPTH);
  localparam int unsigned Cw   = $clog2(CLKS_PER_BIT);
  localparam logic [Cw-1:0]   BitLast  = Cw'(CLKS_PER_BIT - 1);
  localparam logic [Cw-1:0]   HalfLast = Cw'(CLKS_PER_BIT / 2 - 1);
  localparam logic [Cw-1:0]   CntOne   = Cw'(1);
  localparam logic [TxAw:0]   TxPtrOne = (TxAw + 1)'(1);
  localparam logic [RxAw:0]   RxPtrOne = (RxAw + 1)'(1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} uart_state_e;

  // Bus decode
  logic       w_in_win, w_wr, w_rd;
  logic [1:0] w_off;
  logic       w_tx_wr, w_stat_wr, w_ctrl_wr, w_rx_rd;
  logic       w_unused;

  assign w_in_win  = (mem_addr[31:4] == BASE_ADDR[31:4]) && (|mem_en);
  assign w_wr      = w_in_win & mem_wea;
  assign w_rd      = w_in_win & mem_rea;
  assign w_off     = mem_addr[3:2];
  assign w_tx_wr   = w_wr && (w_off == 2'd0);
  assign w_stat_wr = w_wr && (w_off == 2'd2);
  assign w_ctrl_wr = w_wr && (w_off == 2'd3);
  assign w_rx_rd   = w_rd && (w_off == 2'd1);
  assign w_unused  = ^{mem_addr[1:0], mem_din[31:8]};

  // TX FIFO
  logic [7:0]  r_tx_mem [TX_DEPTH];
  logic [TxAw:0] r_tx_wptr, r_tx_rptr;
  logic        w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
  logic [7:0]  w_tx_head;

  assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
  assign w_tx_full  = (r_tx_wptr[TxAw] != r_tx_rptr[TxAw]) &&
                      (r_tx_wptr[TxAw-1:0] == r_tx_rptr[TxAw-1:0]);
  assign w_tx_head  = r_tx_mem[r_tx_rptr[TxAw-1:0]];
  // A pop in the same cycle frees the slot, so the stalled write completes immediately.
  assign w_tx_push  = w_tx_wr && (!w_tx_full || w_tx_pop);
  assign mem_hold   = w_tx_wr && w_tx_full && !w_tx_pop;

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr[TxAw-1:0]] <= mem_din[7:0];
  end

  // RX FIFO
  logic [7:0]  r_rx_mem [RX_DEPTH];
  logic [RxAw:0] r_rx_wptr, r_rx_rptr;
  logic        w_rx_empty, w_rx_full, w_rx_push, w_rx_pop, w_rx_push_req, w_ovr_set;
  logic [7:0]  r_rx_shift;

  assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
  assign w_rx_full  = (r_rx_wptr[RxAw] != r_rx_rptr[RxAw]) &&
                      (r_rx_wptr[RxAw-1:0] == r_rx_rptr[RxAw-1:0]);
  assign w_rx_pop   = w_rx_rd && !w_rx_empty;
  assign w_rx_push  = w_rx_push_req && (!w_rx_full || w_rx_pop);
  assign w_ovr_set  = w_rx_push_req && w_rx_full && !w_rx_pop;

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr[RxAw-1:0]] <= r_rx_shift;
  end

  // TX engine: shift register carries {parity, data} so the parity bit falls out after bit 7
  uart_state_e   r_tx_state, w_tx_state_d;
  logic [Cw-1:0] r_tx_cnt, w_tx_cnt_d;
  logic [2:0]    r_tx_bit, w_tx_bit_d;
  logic [8:0]    r_tx_shift, w_tx_shift_d;
  logic          w_tx_line, w_tx_bit_end;

  assign w_tx_bit_end = (r_tx_cnt == BitLast);

  always_comb begin
    w_tx_state_d = r_tx_state;
    w_tx_cnt_d   = r_tx_cnt + CntOne;
    w_tx_bit_d   = r_tx_bit;
    w_tx_shift_d = r_tx_shift;
    w_tx_pop     = 1'b0;
    w_tx_line    = 1'b1;
    case (r_tx_state)
      StIdle: begin
        w_tx_cnt_d = '0;
        if (!w_tx_empty) begin
          w_tx_pop     = 1'b1;
          w_tx_shift_d = {^w_tx_head, w_tx_head};
          w_tx_state_d = StStart;
        end
      end
      StStart: begin
        w_tx_line = 1'b0;
        if (w_tx_bit_end) begin
          w_tx_cnt_d   = '0;
          w_tx_bit_d   = 3'd0;
          w_tx_state_d = StData;
        end
      end
      StData: begin
        w_tx_line = r_tx_shift[0];
        if (w_tx_bit_end) begin
          w_tx_cnt_d   = '0;
          w_tx_shift_d = {1'b1, r_tx_shift[8:1]};
          w_tx_bit_d   = r_tx_bit + 3'd1;
          if (r_tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
            w_tx_state_d = StParity;
`else
            w_tx_state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        w_tx_line = r_tx_shift[0];
        if (w_tx_bit_end) begin
          w_tx_cnt_d   = '0;
          w_tx_state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_d = '0;
          if (!w_tx_empty) begin
            w_tx_pop     = 1'b1;
            w_tx_shift_d = {^w_tx_head, w_tx_head};
            w_tx_state_d = StStart;
          end else begin
            w_tx_state_d = StIdle;
          end
        end
      end
      default: w_tx_state_d = StIdle;
    endcase
  end

  // RX engine behind a 2-flop synchronizer
  logic          r_rx_s1, r_rx_s2;
  uart_state_e   r_rx_state, w_rx_state_d;
  logic [Cw-1:0] r_rx_cnt, w_rx_cnt_d;
  logic [2:0]    r_rx_bit, w_rx_bit_d;
  logic [7:0]    w_rx_shift_d;
  logic          r_rx_par_bad, w_rx_par_bad_d, w_par_set;
  logic          w_rx_bit_end;

  assign w_rx_bit_end = (r_rx_cnt == BitLast);

  always_comb begin
    w_rx_state_d   = r_rx_state;
    w_rx_cnt_d     = r_rx_cnt + CntOne;
    w_rx_bit_d     = r_rx_bit;
    w_rx_shift_d   = r_rx_shift;
    w_rx_par_bad_d = r_rx_par_bad;
    w_rx_push_req  = 1'b0;
    w_par_set      = 1'b0;
    case (r_rx_state)
      StIdle: begin
        w_rx_cnt_d     = '0;
        w_rx_par_bad_d = 1'b0;
        if (!r_rx_s2) w_rx_state_d = StStart;
      end
      StStart: begin
        if (r_rx_cnt == HalfLast) begin
          w_rx_cnt_d   = '0;
          w_rx_bit_d   = 3'd0;
          w_rx_state_d = r_rx_s2 ? StIdle : StData;
        end
      end
      StData: begin
        if (w_rx_bit_end) begin
          w_rx_cnt_d   = '0;
          w_rx_shift_d = {r_rx_s2, r_rx_shift[7:1]};
          w_rx_bit_d   = r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
            w_rx_state_d = StParity;
`else
            w_rx_state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        if (w_rx_bit_end) begin
          w_rx_cnt_d     = '0;
          w_rx_par_bad_d = ^{r_rx_shift, r_rx_s2};
          w_par_set      = w_rx_par_bad_d;
          w_rx_state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (w_rx_bit_end) begin
          // Framing errors (stop low) are dropped silently
          w_rx_push_req = r_rx_s2 && !r_rx_par_bad;
          w_rx_state_d  = StIdle;
        end
      end
      default: w_rx_state_d = StIdle;
    endcase
  end

  // Register file and read path
  logic        r_irq_en, r_rx_ovr, r_par_err, r_tx, r_hit, w_par_clr;
  logic [31:0] r_dout, w_rdata;

`ifdef UART_PARITY_EN
  assign w_par_clr = w_stat_wr && mem_din[4];
`else
  assign w_par_clr = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    case (w_off)
      2'd1:    w_rdata = {24'b0, w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rptr[RxAw-1:0]]};
      2'd2:    w_rdata = {27'b0, r_par_err, r_rx_ovr, w_tx_full, w_tx_empty, !w_rx_empty};
      2'd3:    w_rdata = {31'b0, r_irq_en};
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_tx_wptr    <= '0;
      r_tx_rptr    <= '0;
      r_rx_wptr    <= '0;
      r_rx_rptr    <= '0;
      r_tx_state   <= StIdle;
      r_tx_cnt     <= '0;
      r_tx_bit     <= '0;
      r_tx_shift   <= '1;
      r_rx_state   <= StIdle;
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_rx_par_bad <= 1'b0;
      r_rx_s1      <= 1'b1;
      r_rx_s2      <= 1'b1;
      r_irq_en     <= 1'b0;
      r_rx_ovr     <= 1'b0;
      r_par_err    <= 1'b0;
      r_tx         <= 1'b1;
      r_hit        <= 1'b0;
      r_dout       <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + TxPtrOne;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + TxPtrOne;
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + RxPtrOne;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + RxPtrOne;
      r_tx_state   <= w_tx_state_d;
      r_tx_cnt     <= w_tx_cnt_d;
      r_tx_bit     <= w_tx_bit_d;
      r_tx_shift   <= w_tx_shift_d;
      r_rx_state   <= w_rx_state_d;
      r_rx_cnt     <= w_rx_cnt_d;
      r_rx_bit     <= w_rx_bit_d;
      r_rx_shift   <= w_rx_shift_d;
      r_rx_par_bad <= w_rx_par_bad_d;
      r_rx_s1      <= rx;
      r_rx_s2      <= r_rx_s1;
      if (w_ctrl_wr) r_irq_en <= mem_din[0];
      if (w_stat_wr && mem_din[3]) r_rx_ovr <= 1'b0;
      if (w_ovr_set) r_rx_ovr <= 1'b1;
      if (w_par_clr) r_par_err <= 1'b0;
      if (w_par_set) r_par_err <= 1'b1;
      r_tx   <= w_tx_line;
      r_hit  <= w_wr | w_rd;
      r_dout <= w_rd ? w_rdata : 32'h0;
    end
  end

  assign tx        = r_tx;
  assign mmio_hit  = r_hit;
  assign mmio_dout = r_dout;
  assign uart_IRQ  = r_irq_en & !w_rx_empty;

endmodule

// File: tb/tb_uart_mmio_periph.sv
// Scoreboard bench for uart_mmio_periph: TX frames decoded by a line monitor, RX bytes
// checked on RXDATA reads; honours UART_PARITY_EN.
module tb_uart_mmio_periph;
  localparam int unsigned CPB  = 16;
  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_din = '0;
  logic        mem_wea = 1'b0;
  logic        mem_rea = 1'b0;
  logic [3:0]  mem_en = '0;
  logic        rx = 1'b1;
  logic        mmio_hit, mem_hold, uart_IRQ, tx;
  logic [31:0] mmio_dout;

  int   n_checks = 0;
  int   n_fail = 0;
  int   n_frames = 0;
  logic mon_en = 1'b0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  uart_mmio_periph #(
    .BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .TX_DEPTH(8), .RX_DEPTH(8)
  ) u_dut (
    .clk(clk), .Rst(Rst), .mem_addr(mem_addr), .mem_din(mem_din), .mem_wea(mem_wea),
    .mem_rea(mem_rea), .mem_en(mem_en), .mmio_hit(mmio_hit), .mmio_dout(mmio_dout),
    .mem_hold(mem_hold), .uart_IRQ(uart_IRQ), .rx(rx), .tx(tx)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // All bus tasks are entered just after a negedge and return just after a negedge.
  task automatic bus_write(input logic [1:0] off, input logic [31:0] d, output int hold);
    mem_addr = {BASE[31:4], off, 2'b00};
    mem_din  = d;
    mem_wea  = 1'b1;
    mem_en   = 4'hF;
    hold     = 0;
    while (mem_hold && hold < 2000) begin
      @(negedge clk);
      hold++;
    end
    if (hold > 0) check_eq("hold_release", 32'(mem_hold), 32'd0);
    @(posedge clk);
    @(negedge clk);
    mem_wea = 1'b0;
    mem_en  = 4'h0;
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [31:0] d);
    mem_addr = {BASE[31:4], off, 2'b00};
    mem_rea  = 1'b1;
    mem_en   = 4'hF;
    @(posedge clk);
    @(negedge clk);
    d = mmio_dout;
    check_eq("rd_hit", 32'(mmio_hit), 32'd1);
    mem_rea = 1'b0;
    mem_en  = 4'h0;
  endtask

  task automatic read_rx_sb();
    logic [31:0] d;
    bus_read(2'd1, d);
    if (rx_exp.size() == 0) check_eq("rx_unexpected_read", d, 32'd0);
    else check_eq("rx_byte", d, {24'b0, rx_exp.pop_front()});
  endtask

  task automatic send_rx(input logic [7:0] d, input logic par_flip);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rx = (^d) ^ par_flip;
    repeat (CPB) @(negedge clk);
`else
    if (par_flip) rx = 1'b1;
`endif
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_tx_drain(input int budget);
    int n = 0;
    while (tx_exp.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("tx_drain", 32'(tx_exp.size()), 32'd0);
    repeat (CPB) @(negedge clk);
  endtask

  task automatic run_len(input logic level, output int len);
    len = 0;
    while (tx == level && len < 4 * CPB) begin
      len++;
      @(negedge clk);
    end
  endtask

  // TX line monitor: decodes frames mid-bit and scores them against tx_exp
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_en && tx == 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        if (mon_en) check_eq("tx_start_mid", 32'(tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
`ifdef UART_PARITY_EN
        repeat (CPB) @(negedge clk);
        if (mon_en) check_eq("tx_parity", 32'(tx), 32'(^b));
`endif
        repeat (CPB) @(negedge clk);
        if (mon_en) begin
          check_eq("tx_stop", 32'(tx), 32'd1);
          if (tx_exp.size() == 0) check_eq("tx_frame_expected", 32'(b), 32'h100);
          else check_eq("tx_byte", 32'(b), 32'(tx_exp.pop_front()));
          n_frames++;
        end
      end
    end
  end

  initial begin : main
    logic [31:0] d;
    logic [7:0]  v;
    int          h, n, len;

    repeat (3) @(posedge clk);
    @(negedge clk);
    Rst = 1'b0;
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_hit", 32'(mmio_hit), 32'd0);
    check_eq("rst_dout", mmio_dout, 32'd0);
    check_eq("rst_hold", 32'(mem_hold), 32'd0);
    check_eq("rst_irq", 32'(uart_IRQ), 32'd0);
    bus_read(2'd2, d);
    check_eq("rst_status", d, 32'h2);
    bus_read(2'd3, d);
    check_eq("rst_ctrl", d, 32'h0);
    mon_en = 1'b1;

    // Accesses outside the window or with no byte enables are ignored
    mem_addr = BASE + 32'h10;
    mem_din  = 32'h77;
    mem_wea  = 1'b1;
    mem_en   = 4'hF;
    @(negedge clk);
    mem_addr = {BASE[31:4], 4'h0};
    mem_en   = 4'h0;
    @(negedge clk);
    check_eq("miss_hit", 32'(mmio_hit), 32'd0);
    mem_wea = 1'b0;
    mem_addr = BASE + 32'h14;
    mem_rea  = 1'b1;
    mem_en   = 4'hF;
    @(negedge clk);
    mem_rea = 1'b0;
    mem_en  = 4'h0;
    check_eq("miss_rd_hit", 32'(mmio_hit), 32'd0);
    check_eq("miss_rd_dout", mmio_dout, 32'd0);
    repeat (4) @(negedge clk);
    check_eq("miss_no_tx", 32'(tx), 32'd1);

    // Single 0x55 frame: check bit timing on the first three runs
    bus_write(2'd0, 32'h55, h);
    tx_exp.push_back(8'h55);
    n = 0;
    while (tx !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("tx_start_seen", 32'(tx), 32'd0);
    run_len(1'b0, len);
    check_eq("start_len", 32'(len), 32'(CPB));
    run_len(1'b1, len);
    check_eq("bit0_len", 32'(len), 32'(CPB));
    run_len(1'b0, len);
    check_eq("bit1_len", 32'(len), 32'(CPB));
    wait_tx_drain(400);

    // One frame in flight, then 9 back-to-back writes: the 9th stalls until the first pop
    bus_write(2'd0, 32'hA5, h);
    tx_exp.push_back(8'hA5);
    for (int i = 0; i < 9; i++) begin
      v = 8'h10 + 8'(i * 7);
      bus_write(2'd0, {24'b0, v}, h);
      tx_exp.push_back(v);
      if (i < 8) check_eq("burst_no_hold", 32'(h), 32'd0);
      else check_eq("burst9_held", 32'(h > 0), 32'd1);
    end
    bus_read(2'd2, d);
    check_eq("status_tx_full", d, 32'h4);
    wait_tx_drain(3000);

    // RX frame with IRQ enabled
    bus_write(2'd3, 32'h1, h);
    bus_read(2'd3, d);
    check_eq("ctrl_rd", d, 32'h1);
    send_rx(8'hA3, 1'b0);
    rx_exp.push_back(8'hA3);
    check_eq("irq_set", 32'(uart_IRQ), 32'd1);
    bus_read(2'd2, d);
    check_eq("status_rx_avail", d, 32'h3);
    read_rx_sb();
    check_eq("irq_clear", 32'(uart_IRQ), 32'd0);
    bus_read(2'd1, d);
    check_eq("rx_empty_read", d, 32'h0);

    // Overflow: 9 frames, no reads
    for (int i = 0; i < 9; i++) begin
      v = 8'(8'h21 + 8'(i * 17));
      send_rx(v, 1'b0);
      if (i < 8) rx_exp.push_back(v);
    end
    bus_read(2'd2, d);
    check_eq("status_ovr", d, 32'h0B);
    bus_write(2'd2, 32'h08, h);
    bus_read(2'd2, d);
    check_eq("status_ovr_clr", d, 32'h03);
    for (int i = 0; i < 8; i++) read_rx_sb();
    bus_read(2'd2, d);
    check_eq("status_rx_drained", d, 32'h02);
    check_eq("irq_drained", 32'(uart_IRQ), 32'd0);

    // One-cycle glitch is rejected
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    bus_read(2'd2, d);
    check_eq("glitch_no_byte", d, 32'h02);

`ifdef UART_PARITY_EN
    send_rx(8'h07, 1'b1);
    bus_read(2'd2, d);
    check_eq("status_par_err", d, 32'h12);
    bus_write(2'd2, 32'h10, h);
    bus_read(2'd2, d);
    check_eq("status_par_clr", d, 32'h02);
`else
    bus_write(2'd2, 32'h18, h);
    bus_read(2'd2, d);
    check_eq("status_par_zero", d, 32'h02);
`endif

    // Reset mid-frame: line idles next cycle and queued bytes are lost
    mon_en = 1'b0;
    bus_write(2'd0, 32'h3C, h);
    bus_write(2'd0, 32'hC3, h);
    bus_write(2'd0, 32'h5A, h);
    n = 0;
    while (tx !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_frame_started", 32'(tx), 32'd0);
    repeat (3 * CPB) @(negedge clk);
    Rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_tx", 32'(tx), 32'd1);
    Rst = 1'b0;
    bus_read(2'd2, d);
    check_eq("rst_mid_status", d, 32'h02);
    bus_read(2'd3, d);
    check_eq("rst_mid_ctrl", d, 32'h0);
    repeat (2 * CPB) @(negedge clk);
    check_eq("rst_mid_idle", 32'(tx), 32'd1);

    check_eq("rx_sb_empty", 32'(rx_exp.size()), 32'd0);
    check_eq("tx_frames", 32'(n_frames), 32'd11);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
